product_accumulator: RTL and testbench

- Downstream consumer of the sequential 4x4 shift-add multiplier.
- Captures each finished `product` when the multiplier raises `op_ready`, and sums a group of N products into a wider accumulator (dot-product / MAC use).
- Presents each group sum through a valid/ready handshake.
- Holds one pending product while a finished sum is stalled, so the multiplier can run ahead by one result.

---
 rtl/product_accumulator_if.sv | 25 ++
 rtl/product_accumulator.sv | 180 ++++++++++++++++++
 tb/tb_product_accumulator.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Bus between the multiplier/consumer side (master) and product_accumulator (slave).
interface product_accumulator_if #(
  parameter int unsigned PW = 8,
  parameter int unsigned AW = 12
);
  logic [PW-1:0] product;
  logic          op_ready;
  logic          clr;
  logic [AW-1:0] sum;
  logic          sum_valid;
  logic          sum_ready;
  logic [7:0]    count;
  logic          overflow;
  logic          lost;

  modport master (
    output product, op_ready, clr, sum_ready,
    input  sum, sum_valid, count, overflow, lost
  );

  modport slave (
    input  product, op_ready, clr, sum_ready,
    output sum, sum_valid, count, overflow, lost
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: captures multiplier products on op_ready rising edges,
// sums groups of N into an AW-bit accumulator and hands each group sum out via
// valid/ready. One product may be parked while a finished sum is stalled.
// Optional macro PRODUCT_ACC_SATURATE_EN: clamp additions at 2^AW-1 instead of wrapping.
module product_accumulator #(
  parameter int unsigned PW = 8,
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 12
) (
  input logic               clk,
  input logic               rst,
  product_accumulator_if.slave bus
);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  localparam logic [7:0] NC = 8'(N);

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [7:0]    count_q, count_d;
  logic [AW-1:0] sum_q, sum_d;
  logic          valid_q, valid_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          pfull_q, pfull_d;
  logic          ovf_q, ovf_d;
  logic          lost_q, lost_d;
  logic          op_q;
  logic          cap;

  logic [AW:0]   r1, r2;
  logic [AW-1:0] a1;
  logic [7:0]    c1, c2;

  // Adds a zero-extended product; bit AW is the carry out.
  function automatic logic [AW:0] add_p(input logic [AW-1:0] a, input logic [PW-1:0] b);
    logic [AW:0] ext;
    logic [AW:0] s;
    ext         = '0;
    ext[PW-1:0] = b;
    s           = {1'b0, a} + ext;
`ifdef PRODUCT_ACC_SATURATE_EN
    if (s[AW]) s[AW-1:0] = '1;
`else
`endif
    return s;
  endfunction

  assign cap = bus.op_ready & ~op_q;

  // Next-state: accumulate in ACC, park/drop products in HOLD, fold on handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    pfull_d = pfull_q;
    lost_d  = lost_q;
    r1      = '0;
    r2      = '0;
    a1      = acc_q;
    c1      = count_q;
    c2      = count_q;

    if (bus.clr) begin
      acc_d   = '0;
      count_d = '0;
      pfull_d = 1'b0;
      if (state_q == ST_HOLD && bus.sum_ready) begin
        valid_d = 1'b0;
        state_d = ST_ACC;
      end
    end else begin
      unique case (state_q)
        ST_ACC: begin
          if (cap) begin
            r2 = add_p(acc_q, bus.product);
            c2 = count_q + 8'd1;
            if (c2 == NC) begin
              sum_d   = r2[AW-1:0];
              valid_d = 1'b1;
              acc_d   = '0;
              count_d = '0;
              state_d = ST_HOLD;
            end else begin
              acc_d   = r2[AW-1:0];
              count_d = c2;
            end
          end
        end
        ST_HOLD: begin
          if (bus.sum_ready) begin
            valid_d = 1'b0;
            state_d = ST_ACC;
            pfull_d = 1'b0;
            // Pending product folds first; a same-cycle capture then follows it,
            // and either step may complete a group (only possible when N is small).
            if (pfull_q) begin
              r1 = add_p(acc_q, pend_q);
              a1 = r1[AW-1:0];
              c1 = count_q + 8'd1;
            end
            if (pfull_q && c1 == NC) begin
              sum_d   = a1;
              valid_d = 1'b1;
              acc_d   = '0;
              count_d = '0;
              state_d = ST_HOLD;
              if (cap) begin
                pend_d  = bus.product;
                pfull_d = 1'b1;
              end
            end else if (cap) begin
              r2 = add_p(a1, bus.product);
              c2 = c1 + 8'd1;
              if (c2 == NC) begin
                sum_d   = r2[AW-1:0];
                valid_d = 1'b1;
                acc_d   = '0;
                count_d = '0;
                state_d = ST_HOLD;
              end else begin
                acc_d   = r2[AW-1:0];
                count_d = c2;
              end
            end else begin
              acc_d   = a1;
              count_d = c1;
            end
          end else if (cap) begin
            if (pfull_q) begin
              lost_d = 1'b1;
            end else begin
              pend_d  = bus.product;
              pfull_d = 1'b1;
            end
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
    ovf_d = ovf_q | r1[AW] | r2[AW];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      pfull_q <= 1'b0;
      ovf_q   <= 1'b0;
      lost_q  <= 1'b0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      pfull_q <= pfull_d;
      ovf_q   <= ovf_d;
      lost_q  <= lost_d;
      op_q    <= bus.op_ready;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.sum_valid = valid_q;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.lost      = lost_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: A (N=4, AW=12), B (N=4, AW=9), C (N=2, AW=12) share stimulus.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] product = '0;
  logic       op_ready = 1'b0;
  logic       clr = 1'b0;
  logic       sum_ready = 1'b0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned hs_a = 0, hs_b = 0, hs_c = 0;
  int unsigned last_a = 0, last_b = 0, last_c = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PW(8), .AW(12)) ifa ();
  product_accumulator_if #(.PW(8), .AW(9))  ifb ();
  product_accumulator_if #(.PW(8), .AW(12)) ifc ();

  assign ifa.product = product;  assign ifa.op_ready = op_ready;
  assign ifa.clr = clr;          assign ifa.sum_ready = sum_ready;
  assign ifb.product = product;  assign ifb.op_ready = op_ready;
  assign ifb.clr = clr;          assign ifb.sum_ready = sum_ready;
  assign ifc.product = product;  assign ifc.op_ready = op_ready;
  assign ifc.clr = clr;          assign ifc.sum_ready = sum_ready;

  product_accumulator #(.PW(8), .N(4), .AW(12)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  product_accumulator #(.PW(8), .N(4), .AW(9))  dut_b (.clk(clk), .rst(rst), .bus(ifb));
  product_accumulator #(.PW(8), .N(2), .AW(12)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // Handshake monitors: count accepted sums and remember the last one.
  always @(posedge clk) begin
    if (rst) begin
      hs_a <= 0; hs_b <= 0; hs_c <= 0;
    end else begin
      if (ifa.sum_valid && ifa.sum_ready) begin hs_a <= hs_a + 1; last_a <= ifa.sum; end
      if (ifb.sum_valid && ifb.sum_ready) begin hs_b <= hs_b + 1; last_b <= ifb.sum; end
      if (ifc.sum_valid && ifc.sum_ready) begin hs_c <= hs_c + 1; last_c <= ifc.sum; end
    end
  end

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One multiplier result: op_ready high for 3 cycles, then low for 1.
  task automatic send(input int unsigned p);
    product  = 8'(p);
    op_ready = 1'b1;
    repeat (3) tick();
    op_ready = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    op_ready = 1'b1;
    clr      = 1'b0;
    repeat (2) tick();
    op_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int unsigned exp_b;

  initial begin
    #1;
    // Reset with op_ready held high.
    do_reset();
    check_eq("rst_sum", ifa.sum, 0);
    check_eq("rst_valid", ifa.sum_valid, 0);
    check_eq("rst_count", ifa.count, 0);
    check_eq("rst_ovf", ifa.overflow, 0);
    check_eq("rst_lost", ifa.lost, 0);
    send(5);
    check_eq("first_cap_once", ifa.count, 1);

    // Group sum with sum_ready high.
    do_reset();
    sum_ready = 1'b1;
    send(36); send(110); send(225); send(36);
    check_eq("grp_hs", hs_a, 1);
    check_eq("grp_sum", last_a, 407);
    check_eq("grp_count", ifa.count, 0);
    check_eq("grp_valid", ifa.sum_valid, 0);
    check_eq("grp_ovf", ifa.overflow, 0);
    check_eq("grp_lost", ifa.lost, 0);

    // Backpressure: 900 stalled, 10 parked, 20 dropped.
    do_reset();
    sum_ready = 1'b0;
    send(225); send(225); send(225); send(225);
    send(10); send(20);
    check_eq("bp_sum", ifa.sum, 900);
    check_eq("bp_valid", ifa.sum_valid, 1);
    check_eq("bp_lost", ifa.lost, 1);
    check_eq("bp_count", ifa.count, 0);
    check_eq("bp_hs0", hs_a, 0);
    sum_ready = 1'b1;
    tick();
    check_eq("bp_rel_valid", ifa.sum_valid, 0);
    check_eq("bp_rel_count", ifa.count, 1);
    check_eq("bp_rel_hs", hs_a, 1);
    send(1); send(1); send(1);
    check_eq("bp_next_sum", last_a, 13);
    check_eq("bp_next_hs", hs_a, 2);

    // clr mid-group together with a capture.
    do_reset();
    sum_ready = 1'b1;
    send(36); send(110);
    check_eq("clr_pre_count", ifa.count, 2);
    product  = 8'd225;
    op_ready = 1'b1;
    clr      = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_count", ifa.count, 0);
    repeat (2) tick();
    op_ready = 1'b0;
    tick();
    check_eq("clr_held_count", ifa.count, 0);
    send(1); send(1); send(1); send(1);
    check_eq("clr_sum", last_a, 4);
    check_eq("clr_hs", hs_a, 1);

    // Overflow on the 9-bit instance.
    do_reset();
    sum_ready = 1'b1;
    send(225); send(225); send(225); send(225);
`ifdef PRODUCT_ACC_SATURATE_EN
    exp_b = 511;
`else
    exp_b = 388;
`endif
    check_eq("ovf_sum", last_b, exp_b);
    check_eq("ovf_flag", ifb.overflow, 1);
    check_eq("ovf_hs", hs_b, 1);
    check_eq("wide_sum", last_a, 900);
    check_eq("wide_ovf", ifa.overflow, 0);

    // N=2: handshake and capture together with a pending product.
    do_reset();
    sum_ready = 1'b0;
    send(3); send(4);
    send(5);
    check_eq("n2_sum7", ifc.sum, 7);
    check_eq("n2_valid", ifc.sum_valid, 1);
    check_eq("n2_lost", ifc.lost, 0);
    product   = 8'd7;
    op_ready  = 1'b1;
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check_eq("n2_hs", hs_c, 1);
    check_eq("n2_hs_sum", last_c, 7);
    check_eq("n2_new_valid", ifc.sum_valid, 1);
    check_eq("n2_new_sum", ifc.sum, 12);
    check_eq("n2_count", ifc.count, 0);
    op_ready = 1'b0;
    repeat (2) tick();
    check_eq("n2_hold_sum", ifc.sum, 12);
    check_eq("n2_hold_valid", ifc.sum_valid, 1);
    check_eq("n2_lost_end", ifc.lost, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
